// File: rtl/rgb_seq_pkg.sv
// rgb_seq_pkg
// Shared definitions for the RGB fade sequencer.
// Contents:
//   seq_state_t : controller states (IDLE, FADE, FINISH)
package rgb_seq_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    FADE   = 2'd1,
    FINISH = 2'd2
  } seq_state_t;

endpackage

// File: rtl/rgb_ramp_channel.sv
// rgb_ramp_channel
// One colour channel of the fade sequencer. Holds the channel's target and
// duty registers and walks the duty one LSB toward the target on each step.
// Ports:
//   clk, reset   : clock, synchronous active-high reset
//   load         : capture target_in (clamped to full scale) as the new target
//   jump         : with load, also copy the clamped target straight to duty
//   step         : move duty one LSB toward target (if not already there)
//   hold         : freeze the duty; overrides step
//   target_in    : requested target duty, R+1 bits
//   duty         : registered duty for the PWM driver
//   at_target    : duty equals the stored target
module rgb_ramp_channel #(
  parameter int R = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       load,
  input  logic       jump,
  input  logic       step,
  input  logic       hold,
  input  logic [R:0] target_in,
  output logic [R:0] duty,
  output logic       at_target
);

  localparam logic [R:0] FULL_SCALE = {1'b1, {R{1'b0}}};
  localparam logic [R:0] ONE        = {{R{1'b0}}, 1'b1};

  logic [R:0] target;
  logic [R:0] clamped;

  // The duty bus can express values above full scale; those are meaningless
  // to the driver, so they are stored as full scale.
  assign clamped   = (target_in > FULL_SCALE) ? FULL_SCALE : target_in;
  assign at_target = (duty == target);

  // A jump lands on the target in one edge; otherwise the duty only ever
  // moves by one LSB, so it can never overshoot the target.
  always_ff @(posedge clk) begin
    if (reset) begin
      target <= '0;
      duty   <= '0;
    end else begin
      if (load) begin
        target <= clamped;
      end
      if (load && jump) begin
        duty <= clamped;
      end else if (step && !hold && !at_target) begin
        duty <= (duty < target) ? duty + ONE : duty - ONE;
      end
    end
  end

endmodule

// File: rtl/rgb_fade_sequencer.sv
// rgb_fade_sequencer
// Accepts colour commands over valid/ready and either jumps to the target
// colour or fades toward it one LSB per step tick on every channel.
// Ports:
//   clk, reset                      : clock, synchronous active-high reset
//   cmd_valid / cmd_ready           : command handshake (ready only in IDLE)
//   cmd_red, cmd_green, cmd_blue    : target duties, R+1 bits each
//   cmd_fade                        : 1 = fade, 0 = jump
//   abort                           : stop an in-progress fade
//   red_duty, green_duty, blue_duty : registered duties to rgb_driver
//   busy                            : a command is in progress
//   done                            : one-cycle pulse at completion or abort
module rgb_fade_sequencer
  import rgb_seq_pkg::*;
#(
  parameter int R        = 8,
  parameter int TICK_DIV = 100000,
  parameter int DIV_BITS = 17
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic [R:0] cmd_red,
  input  logic [R:0] cmd_green,
  input  logic [R:0] cmd_blue,
  input  logic       cmd_fade,
  input  logic       abort,
  output logic [R:0] red_duty,
  output logic [R:0] green_duty,
  output logic [R:0] blue_duty,
  output logic       busy,
  output logic       done
);

  localparam logic [DIV_BITS-1:0] TICK_LAST = DIV_BITS'(TICK_DIV - 1);
  localparam logic [DIV_BITS-1:0] DIV_ONE   = {{(DIV_BITS-1){1'b0}}, 1'b1};

  seq_state_t          state;
  seq_state_t          next_state;
  logic [DIV_BITS-1:0] tick_count;
  logic                accept;
  logic                load_jump;
  logic                step_tick;
  logic [2:0]          at_target;
  logic                all_at_target;
  logic                ready_next;
  logic                busy_next;
  logic                done_next;

  // cmd_ready is itself a register, so the handshake uses its current value.
  assign accept        = cmd_valid && cmd_ready;
  assign load_jump     = !cmd_fade;
  assign step_tick     = (state == FADE) && (tick_count == TICK_LAST);
  assign all_at_target = &at_target;

  // State, tick divider and registered outputs. The outputs are loaded from
  // the decoded next state so they line up with the state they describe,
  // and cmd_ready stays low for as long as reset is held.
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      tick_count <= '0;
      cmd_ready  <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
    end else begin
      state     <= next_state;
      cmd_ready <= ready_next;
      busy      <= busy_next;
      done      <= done_next;
      if (accept && cmd_fade) begin
        tick_count <= '0;
      end else if (state == FADE) begin
        tick_count <= step_tick ? '0 : tick_count + DIV_ONE;
      end
    end
  end

  // Next-state decode. A fade whose target already matches the current
  // colour finishes one cycle after accept through the all-at-target check.
  always_comb begin
    next_state = state;
    case (state)
      IDLE: begin
        if (accept) begin
          next_state = cmd_fade ? FADE : FINISH;
        end
      end
      FADE: begin
        if (abort || all_at_target) begin
          next_state = FINISH;
        end
      end
      FINISH:  next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // Output decode from the upcoming state.
  always_comb begin
    ready_next = (next_state == IDLE);
    busy_next  = (next_state != IDLE);
    done_next  = (next_state == FINISH);
  end

  // Abort drives hold so a step tick on the same cycle is suppressed.
  rgb_ramp_channel #(.R(R)) u_red (
    .clk       (clk),
    .reset     (reset),
    .load      (accept),
    .jump      (load_jump),
    .step      (step_tick),
    .hold      (abort),
    .target_in (cmd_red),
    .duty      (red_duty),
    .at_target (at_target[0])
  );

  rgb_ramp_channel #(.R(R)) u_green (
    .clk       (clk),
    .reset     (reset),
    .load      (accept),
    .jump      (load_jump),
    .step      (step_tick),
    .hold      (abort),
    .target_in (cmd_green),
    .duty      (green_duty),
    .at_target (at_target[1])
  );

  rgb_ramp_channel #(.R(R)) u_blue (
    .clk       (clk),
    .reset     (reset),
    .load      (accept),
    .jump      (load_jump),
    .step      (step_tick),
    .hold      (abort),
    .target_in (cmd_blue),
    .duty      (blue_duty),
    .at_target (at_target[2])
  );

endmodule
